// File: rtl/player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_ctrl
// Purpose  : Player-ship controller: position, lives, level, game flow and
//            rate-limited firing. Define PLAYER_INVULN_EN for post-resume
//            invulnerability frames.
// Revision : 1.0 - initial release
// ============================================================================
module player_ctrl #(
    parameter int SCREEN_W_P    = 640,
    parameter int SHIP_W_P      = 36,
    parameter int BORDER_P      = 8,
    parameter int STEP_P        = 2,
    parameter int START_X_P     = 250,
    parameter int START_LIVES_P = 2,
    parameter int MAX_LIVES_P   = 3,
    parameter int LEVELS_P      = 8,
    parameter int BONUS_EVERY_P = 2,
    parameter int COOLDOWN_P    = 16,
    parameter int INVULN_P      = 60,
    parameter int X_W_P         = 10,
    parameter int LIV_W_P       = $clog2(MAX_LIVES_P + 1),
    parameter int LVL_W_P       = $clog2(LEVELS_P + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               frame_i,
    input  logic               move_left_i,
    input  logic               move_right_i,
    input  logic               shoot_i,
    input  logic               hit_i,
    input  logic               level_clear_i,
    output logic               alive_o,
    output logic               paused_o,
    output logic [X_W_P-1:0]   pos_left_o,
    output logic [X_W_P-1:0]   pos_right_o,
    output logic [LIV_W_P-1:0] lives_o,
    output logic [LVL_W_P-1:0] level_o,
    output logic               shot_o,
    output logic               level_beat_o,
    output logic               game_won_o,
    output logic [5:0]         state_o
);

    localparam logic [5:0] ST_STOP  = 6'b000001;
    localparam logic [5:0] ST_LEFT  = 6'b000010;
    localparam logic [5:0] ST_RIGHT = 6'b000100;
    localparam logic [5:0] ST_HIT   = 6'b001000;
    localparam logic [5:0] ST_DEAD  = 6'b010000;
    localparam logic [5:0] ST_WON   = 6'b100000;

    localparam int CD_W  = $clog2(COOLDOWN_P + 1);
    localparam int INV_W = $clog2(INVULN_P + 1);

    localparam logic [X_W_P-1:0]   MIN_X       = X_W_P'(BORDER_P);
    localparam logic [X_W_P-1:0]   MAX_X       = X_W_P'(SCREEN_W_P - BORDER_P - SHIP_W_P);
    localparam logic [X_W_P-1:0]   STEP_X      = X_W_P'(STEP_P);
    localparam logic [X_W_P-1:0]   START_X     = X_W_P'(START_X_P);
    localparam logic [X_W_P-1:0]   SHIP_SPAN   = X_W_P'(SHIP_W_P - 1);
    localparam logic [LIV_W_P-1:0] START_LIVES = LIV_W_P'(START_LIVES_P);
    localparam logic [LIV_W_P-1:0] MAX_LIVES   = LIV_W_P'(MAX_LIVES_P);
    localparam logic [LVL_W_P-1:0] LAST_LEVEL  = LVL_W_P'(LEVELS_P);
    localparam logic [LVL_W_P-1:0] FIRST_LEVEL = LVL_W_P'(1);
    localparam logic [CD_W-1:0]    CD_LOAD     = CD_W'(COOLDOWN_P);

    logic [5:0]         state, state_nx;
    logic [X_W_P-1:0]   pos_left, pos_nx;
    logic [LIV_W_P-1:0] lives, lives_nx;
    logic [LVL_W_P-1:0] level, level_nx;
    logic [CD_W-1:0]    cooldown, cool_nx;
    logic               shoot_q, shot, shot_nx, level_beat, beat_nx;
    logic               shot_edge, active, hit_taken, bonus, resume, restart;

    assign shot_edge = shoot_i & ~shoot_q;
    assign active    = (state == ST_STOP) || (state == ST_LEFT) || (state == ST_RIGHT);
    assign bonus     = ((32'(level) + 32'd1) % BONUS_EVERY_P) == 0;

`ifdef PLAYER_INVULN_EN
    logic [INV_W-1:0] invuln;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            invuln <= '0;
        end else if (restart) begin
            invuln <= '0;
        end else if (resume) begin
            invuln <= INV_W'(INVULN_P);
        end else if (frame_i && invuln != '0) begin
            invuln <= invuln - INV_W'(1);
        end
    end
`else
    logic [INV_W-1:0] invuln;
    assign invuln = '0;
`endif

    assign hit_taken = hit_i && (invuln == '0);

    always_comb begin
        state_nx = state;
        pos_nx   = pos_left;
        lives_nx = lives;
        level_nx = level;
        cool_nx  = cooldown;
        shot_nx  = 1'b0;
        beat_nx  = 1'b0;
        resume   = 1'b0;
        restart  = 1'b0;

        // HIT freezes the cooldown along with everything else
        if (frame_i && cooldown != '0 && state != ST_HIT) begin
            cool_nx = cooldown - CD_W'(1);
        end
        if (frame_i && state == ST_LEFT) begin
            pos_nx = (pos_left >= MIN_X + STEP_X) ? pos_left - STEP_X : MIN_X;
        end
        if (frame_i && state == ST_RIGHT) begin
            pos_nx = (pos_left <= MAX_X - STEP_X) ? pos_left + STEP_X : MAX_X;
        end

        if (active) begin
            if (hit_taken) begin
                if (lives != '0) begin
                    state_nx = ST_HIT;
                    lives_nx = lives - LIV_W_P'(1);
                end else begin
                    state_nx = ST_DEAD;
                end
            end else begin
                if (level_clear_i) begin
                    beat_nx = 1'b1;
                    if (level == LAST_LEVEL) begin
                        state_nx = ST_WON;
                    end else begin
                        level_nx = level + LVL_W_P'(1);
                        if (bonus && lives < MAX_LIVES) begin
                            lives_nx = lives + LIV_W_P'(1);
                        end
                    end
                end else if (move_left_i ^ move_right_i) begin
                    state_nx = move_left_i ? ST_LEFT : ST_RIGHT;
                end else begin
                    state_nx = ST_STOP;
                end
                if (shot_edge && cooldown == '0) begin
                    shot_nx = 1'b1;
                    cool_nx = CD_LOAD;
                end
            end
        end else if (state == ST_HIT) begin
            if (shot_edge) begin
                state_nx = ST_STOP;
                resume   = 1'b1;
            end
        end else if (shot_edge) begin
            restart  = 1'b1;
            state_nx = ST_STOP;
            pos_nx   = START_X;
            lives_nx = START_LIVES;
            level_nx = FIRST_LEVEL;
            cool_nx  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state      <= ST_STOP;
            pos_left   <= START_X;
            lives      <= START_LIVES;
            level      <= FIRST_LEVEL;
            cooldown   <= '0;
            shoot_q    <= 1'b0;
            shot       <= 1'b0;
            level_beat <= 1'b0;
        end else begin
            state      <= state_nx;
            pos_left   <= pos_nx;
            lives      <= lives_nx;
            level      <= level_nx;
            cooldown   <= cool_nx;
            shoot_q    <= shoot_i;
            shot       <= shot_nx;
            level_beat <= beat_nx;
        end
    end

    assign state_o      = state;
    assign pos_left_o   = pos_left;
    assign pos_right_o  = pos_left + SHIP_SPAN;
    assign lives_o      = lives;
    assign level_o      = level;
    assign shot_o       = shot;
    assign level_beat_o = level_beat;
    assign alive_o      = (state != ST_DEAD);
    assign paused_o     = (state == ST_HIT) || (state == ST_DEAD) || (state == ST_WON);
    assign game_won_o   = (state == ST_WON);

endmodule
`default_nettype wire

// File: tb/tb_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_ctrl
// Purpose  : Self-checking bench for player_ctrl against a game-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_ctrl;

    localparam int S_STOP = 0, S_LEFT = 1, S_RIGHT = 2, S_HIT = 3, S_DEAD = 4, S_WON = 5;
`ifdef PLAYER_INVULN_EN
    localparam int INV = 60;
`else
    localparam int INV = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0, frame = 1'b0, mv_l = 1'b0, mv_r = 1'b0;
    logic       shoot = 1'b0, hit = 1'b0, clr = 1'b0;
    logic       alive, paused, shot, beat, won;
    logic [9:0] pos_l, pos_r;
    logic [1:0] lives;
    logic [3:0] level;
    logic [5:0] state;

    int n_cmp = 0, n_bad = 0;
    int m_st, m_pos, m_liv, m_lvl, m_cool, m_inv;
    bit m_prev, m_shot, m_beat;

    player_ctrl dut (
        .clk_i(clk), .reset_n_i(reset_n), .frame_i(frame),
        .move_left_i(mv_l), .move_right_i(mv_r), .shoot_i(shoot),
        .hit_i(hit), .level_clear_i(clr),
        .alive_o(alive), .paused_o(paused), .pos_left_o(pos_l), .pos_right_o(pos_r),
        .lives_o(lives), .level_o(level), .shot_o(shot), .level_beat_o(beat),
        .game_won_o(won), .state_o(state)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, advance the game-rule model, sample 1 ns after the edge.
    task automatic cycle(input bit rst, input bit fr, input bit l, input bit r,
                         input bit sh, input bit h, input bit c);
        int n_st, n_pos, n_liv, n_lvl, n_cool, n_inv;
        bit n_shot, n_beat, edge_sh;
        reset_n = !rst; frame = fr; mv_l = l; mv_r = r; shoot = sh; hit = h; clr = c;
        edge_sh = sh && !m_prev;
        n_st = m_st; n_pos = m_pos; n_liv = m_liv; n_lvl = m_lvl; n_cool = m_cool; n_inv = m_inv;
        n_shot = 0; n_beat = 0;
        if (fr && m_cool > 0 && m_st != S_HIT) n_cool = m_cool - 1;
        if (fr && m_inv > 0) n_inv = m_inv - 1;
        if (fr && m_st == S_LEFT)  n_pos = (m_pos - 2 < 8) ? 8 : m_pos - 2;
        if (fr && m_st == S_RIGHT) n_pos = (m_pos + 2 > 596) ? 596 : m_pos + 2;
        if (m_st <= S_RIGHT) begin
            if (h && m_inv == 0) begin
                if (m_liv > 0) begin n_st = S_HIT; n_liv = m_liv - 1; end
                else n_st = S_DEAD;
            end else begin
                if (c) begin
                    n_beat = 1;
                    if (m_lvl == 8) n_st = S_WON;
                    else begin
                        n_lvl = m_lvl + 1;
                        if (n_lvl % 2 == 0 && m_liv < 3) n_liv = m_liv + 1;
                    end
                end else if (l != r) n_st = l ? S_LEFT : S_RIGHT;
                else n_st = S_STOP;
                if (edge_sh && m_cool == 0) begin n_shot = 1; n_cool = 16; end
            end
        end else if (m_st == S_HIT) begin
            if (edge_sh) begin n_st = S_STOP; n_inv = INV; end
        end else if (edge_sh) begin
            n_st = S_STOP; n_pos = 250; n_liv = 2; n_lvl = 1; n_cool = 0; n_inv = 0;
        end
        if (rst) begin
            n_st = S_STOP; n_pos = 250; n_liv = 2; n_lvl = 1; n_cool = 0; n_inv = 0;
            n_shot = 0; n_beat = 0;
        end
        @(posedge clk);
        #1;
        m_st = n_st; m_pos = n_pos; m_liv = n_liv; m_lvl = n_lvl; m_cool = n_cool;
        m_inv = n_inv; m_shot = n_shot; m_beat = n_beat; m_prev = rst ? 1'b0 : sh;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, i[0], 0, 0);
        cycle(1, 1, 1, 0, 1, 1, 1);
        n_cmp++; if (state !== 6'b000001) begin n_bad++; $display("FAIL reset_state: got %b want 000001", state); end
        n_cmp++; if (pos_l !== 10'd250) begin n_bad++; $display("FAIL reset_pos: got %0d want 250", pos_l); end
        n_cmp++; if (lives !== 2'd2 || level !== 4'd1) begin n_bad++; $display("FAIL reset_lives_level: got %0d/%0d want 2/1", lives, level); end
        n_cmp++; if ({alive, paused, shot, beat, won} !== 5'b10000) begin n_bad++; $display("FAIL reset_flags: got %b want 10000", {alive, paused, shot, beat, won}); end
        cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_move_left();
        cycle(0, 0, 1, 0, 0, 0, 0);
        n_cmp++; if (state !== 6'b000010) begin n_bad++; $display("FAIL left_state: got %b want 000010", state); end
        for (int i = 0; i < 200; i++) begin
            cycle(0, 1, 1, 0, 0, 0, 0);
            n_cmp++; if (pos_l !== 10'(m_pos) || state !== 6'b000010) begin
                n_bad++; $display("FAIL left_step%0d: got pos %0d state %b want pos %0d state 000010", i, pos_l, state, m_pos);
            end
            if (i == 0) begin
                n_cmp++; if (pos_l !== 10'd248) begin n_bad++; $display("FAIL left_first: got %0d want 248", pos_l); end
            end
            cycle(0, 0, 1, 0, 0, 0, 0);
        end
        n_cmp++; if (pos_l !== 10'd8) begin n_bad++; $display("FAIL left_sat: got %0d want 8", pos_l); end
    endtask

    task automatic test_move_right();
        for (int i = 0; i < 320; i++) begin
            cycle(0, 1, 0, 1, 0, 0, 0);
            cycle(0, 0, 0, 1, 0, 0, 0);
        end
        n_cmp++; if (pos_l !== 10'd596 || pos_r !== 10'd631 || state !== 6'b000100) begin
            n_bad++; $display("FAIL right_sat: got %0d/%0d %b want 596/631 000100", pos_l, pos_r, state);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 1, 1, 0, 0, 0);
            cycle(0, 0, 1, 1, 0, 0, 0);
        end
        n_cmp++; if (state !== 6'b000001 || pos_l !== 10'd596) begin
            n_bad++; $display("FAIL both_buttons: got %b pos %0d want 000001 pos 596", state, pos_l);
        end
    endtask

    task automatic test_shoot_cooldown();
        bit want;
        for (int f = 0; f <= 20; f++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, (f == 0 || f == 5 || f == 16), 0, 0);
            want = (f == 0 || f == 16);
            n_cmp++; if (shot !== want) begin n_bad++; $display("FAIL shot_frame%0d: got %b want %b", f, shot, want); end
            cycle(0, 0, 0, 0, 0, 0, 0);
            n_cmp++; if (shot !== 1'b0) begin n_bad++; $display("FAIL shot_width%0d: got %b want 0", f, shot); end
        end
    endtask

    task automatic test_hit_dead_restart();
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin cycle(0, 1, 1, 0, 0, 0, 0); cycle(0, 0, 1, 0, 0, 0, 0); end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i <= INV; i++) cycle(0, 1, 0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 1, 0);
            if (k < 2) begin
                n_cmp++; if (state !== 6'b001000 || lives !== 2'(1 - k) || !paused || !alive) begin
                    n_bad++; $display("FAIL hit%0d: got %b lives %0d want 001000 lives %0d", k, state, lives, 1 - k);
                end
                cycle(0, 0, 0, 0, 1, 0, 0);
                n_cmp++; if (state !== 6'b000001 || shot !== 1'b0) begin
                    n_bad++; $display("FAIL resume%0d: got %b shot %b want 000001 shot 0", k, state, shot);
                end
                cycle(0, 0, 0, 0, 0, 0, 0);
            end else begin
                n_cmp++; if (state !== 6'b010000 || alive !== 1'b0 || paused !== 1'b1 || lives !== 2'd0) begin
                    n_bad++; $display("FAIL dead: got %b alive %b lives %0d want 010000 alive 0 lives 0", state, alive, lives);
                end
            end
        end
        cycle(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (state !== 6'b000001 || lives !== 2'd2 || level !== 4'd1 || pos_l !== 10'd250) begin
            n_bad++; $display("FAIL restart: got %b %0d %0d %0d want 000001 2 1 250", state, lives, level, pos_l);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_levels_won();
        int exp_lv[7] = '{2, 2, 3, 3, 3, 3, 3};
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 1);
            n_cmp++; if (beat !== 1'b1) begin n_bad++; $display("FAIL beat%0d: got %b want 1", i, beat); end
            if (i < 7) begin
                n_cmp++; if (level !== 4'(i + 2) || lives !== 2'(exp_lv[i])) begin
                    n_bad++; $display("FAIL level%0d: got lvl %0d lives %0d want lvl %0d lives %0d", i, level, lives, i + 2, exp_lv[i]);
                end
            end else begin
                n_cmp++; if (state !== 6'b100000 || won !== 1'b1 || level !== 4'd8) begin
                    n_bad++; $display("FAIL won: got %b won %b lvl %0d want 100000 1 8", state, won, level);
                end
            end
            cycle(0, 0, 0, 0, 0, 0, 0);
            n_cmp++; if (beat !== 1'b0) begin n_bad++; $display("FAIL beat_width%0d: got %b want 0", i, beat); end
        end
    endtask

    task automatic test_hit_vs_clear();
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 1);
        n_cmp++; if (state !== 6'b001000 || level !== 4'd1 || lives !== 2'd1 || beat !== 1'b0) begin
            n_bad++; $display("FAIL hit_vs_clear: got %b lvl %0d lives %0d beat %b want 001000 1 1 0", state, level, lives, beat);
        end
    endtask

`ifdef PLAYER_INVULN_EN
    task automatic test_invuln();
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (state !== 6'b000001 || lives !== 2'd1) begin
            n_bad++; $display("FAIL invuln_ignore: got %b lives %0d want 000001 1", state, lives);
        end
        for (int i = 0; i < 51; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);
        n_cmp++; if (state !== 6'b001000 || lives !== 2'd0) begin
            n_bad++; $display("FAIL invuln_expire: got %b lives %0d want 001000 0", state, lives);
        end
    endtask
`endif

    task automatic test_random();
        bit l = 0, r = 0, sh = 0;
        logic [36:0] got, want;
        cycle(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(7) == 0) l = ~l;
            if ($urandom_range(7) == 0) r = ~r;
            if ($urandom_range(2) == 0) sh = ~sh;
            cycle($urandom_range(699) == 0, $urandom_range(3) == 0, l, r, sh,
                  $urandom_range(39) == 0, $urandom_range(24) == 0);
            want = {6'(1 << m_st), 10'(m_pos), 10'(m_pos + 35), 2'(m_liv), 4'(m_lvl),
                    m_shot, m_beat, (m_st != S_DEAD), (m_st >= S_HIT), (m_st == S_WON)};
            got  = {state, pos_l, pos_r, lives, level, shot, beat, alive, paused, won};
            n_cmp++; if (got !== want) begin
                n_bad++; $display("FAIL random%0d: got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        m_st = S_STOP; m_pos = 250; m_liv = 2; m_lvl = 1; m_cool = 0; m_inv = 0;
        m_prev = 0; m_shot = 0; m_beat = 0;
        test_reset();
        test_move_left();
        test_move_right();
        test_shoot_cooldown();
        test_hit_dead_restart();
        test_levels_won();
        test_hit_vs_clear();
`ifdef PLAYER_INVULN_EN
        test_invuln();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
